// File: rtl/mac_acc_stage.sv
// Accumulates TAPS signed-weighted products per window and presents the window sum.
// Define MAC_ACC_ABS_EN to load the absolute value of the sum into result.
module mac_acc_stage #(
    parameter int TAPS  = 9,
    parameter int ACC_W = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       product,
    input  logic             sub,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             clr,
    output logic [ACC_W-1:0] result,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(TAPS - 1);

    typedef enum logic {
        ACCUM,
        HOLD
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_nx;
    logic [ACC_W-1:0] prod_x;
    logic [ACC_W-1:0] final_val;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             last;

    assign prod_x = ACC_W'(product);
    assign acc_nx = sub ? acc - prod_x : acc + prod_x;
    assign accept = in_valid & in_ready;
    assign last   = accept && (cnt == LAST);

`ifdef MAC_ACC_ABS_EN
    assign final_val = acc_nx[ACC_W-1] ? -acc_nx : acc_nx;
`else
    assign final_val = acc_nx;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ACCUM: if (last) state_nx = HOLD;
            HOLD:  if (out_ready) state_nx = ACCUM;
            default: state_nx = ACCUM;
        endcase
    end

    always_comb begin
        in_ready  = (state == ACCUM) && !clr;
        out_valid = (state == HOLD);
    end

    // clr wins over a coincident product; it is ignored entirely in HOLD
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
        end else if (state == ACCUM) begin
            if (clr) begin
                acc <= '0;
                cnt <= '0;
            end else if (last) begin
                result <= final_val;
                acc    <= '0;
                cnt    <= '0;
            end else if (accept) begin
                acc <= acc_nx;
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mac_acc_stage.sv
// Self-checking bench for mac_acc_stage: directed scenarios plus random traffic
// compared cycle by cycle against a window-sum reference model.
module tb_mac_acc_stage;

    localparam int TAPS  = 9;
    localparam int ACC_W = 13;

    logic             clk;
    logic             rst;
    logic [7:0]       product;
    logic             sub;
    logic             in_valid;
    logic             in_ready;
    logic             clr;
    logic [ACC_W-1:0] result;
    logic             out_valid;
    logic             out_ready;

    int checks;
    int errors;

    // reference model state
    int m_sum;
    int m_taps;
    bit m_hold;
    int m_res;

    mac_acc_stage #(.TAPS(TAPS), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .product   (product),
        .sub       (sub),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .clr       (clr),
        .result    (result),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int final_of(int s);
        int w;
        w = s % (1 << ACC_W);
        if (w >= (1 << (ACC_W - 1))) w -= (1 << ACC_W);
        if (w < -(1 << (ACC_W - 1))) w += (1 << ACC_W);
`ifdef MAC_ACC_ABS_EN
        if (w < 0) w = -w;
`endif
        return w;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic model_reset();
        m_sum  = 0;
        m_taps = 0;
        m_hold = 0;
        m_res  = 0;
    endtask

    // Called at posedge+1: drive inputs, check outputs, advance model, step clock.
    task automatic cyc(bit v, int p, bit s, bit c, bit ordy);
        logic [31:0] r;
        in_valid  = v;
        product   = 8'(p);
        sub       = s;
        clr       = c;
        out_ready = ordy;
        #1;
        r = 32'($signed(result));
        chk("in_ready", 32'(in_ready), 32'(!m_hold && !c));
        chk("out_valid", 32'(out_valid), 32'(m_hold));
        chk("result", r, 32'(m_res));
        if (!m_hold) begin
            if (c) begin
                m_sum  = 0;
                m_taps = 0;
            end else if (v) begin
                m_sum += s ? -p : p;
                m_taps++;
                if (m_taps == TAPS) begin
                    m_res  = final_of(m_sum);
                    m_hold = 1;
                    m_sum  = 0;
                    m_taps = 0;
                end
            end
        end else if (ordy) begin
            m_hold = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int seqa[9];
        bit suba[9];
        checks = 0;
        errors = 0;
        rst = 1'b1;
        product = '0;
        sub = 1'b0;
        in_valid = 1'b0;
        clr = 1'b0;
        out_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // nine products of 225, back-to-back
        for (int i = 0; i < 9; i++) cyc(1, 225, 0, 0, 1);
        chk("sum2025", 32'($signed(result)), 32'(final_of(2025)));
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);

        // Sobel-like windows
        seqa = '{10, 20, 10, 10, 20, 10, 0, 0, 0};
        suba = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
        for (int i = 0; i < 9; i++) cyc(1, seqa[i], suba[i], 0, 1);
        chk("sobel0", 32'($signed(result)), 32'd0);
        cyc(0, 0, 0, 0, 1);
        seqa = '{0, 0, 0, 0, 0, 0, 10, 20, 30};
        suba = '{0, 0, 0, 0, 0, 0, 1, 1, 1};
        for (int i = 0; i < 9; i++) cyc(1, seqa[i], suba[i], 0, 1);
`ifdef MAC_ACC_ABS_EN
        chk("sobel60", 32'($signed(result)), 32'd60);
`else
        chk("sobel60", 32'($signed(result)), -32'sd60);
`endif
        cyc(0, 0, 0, 0, 1);

        // downstream stall for 5 cycles, in_valid and clr pushing meanwhile
        for (int i = 0; i < 9; i++) cyc(1, 3, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 50, 0, (i == 2), 0);
        cyc(1, 50, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);

        // clr with in_valid drops the product
        for (int i = 0; i < 4; i++) cyc(1, 100, 1, 0, 1);
        cyc(1, 77, 0, 1, 1);
        for (int i = 0; i < 9; i++) cyc(1, 1, 0, 0, 1);
        chk("clr9", 32'($signed(result)), 32'd9);
        cyc(0, 0, 0, 0, 1);

        // reset mid-window
        for (int i = 0; i < 5; i++) cyc(1, 40, 0, 0, 1);
        do_reset();
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 9; i++) cyc(1, 2, 0, 0, 1);
        chk("rst18", 32'($signed(result)), 32'd18);
        cyc(0, 0, 0, 0, 0);

        // reset while holding a result
        do_reset();
        cyc(0, 0, 0, 0, 1);

        // gapped input
        for (int i = 0; i < 9; i++) begin
            cyc(1, 7, 0, 0, 1);
            if (i < 8) cyc(0, 0, 0, 0, 1);
        end
        chk("gap63", 32'($signed(result)), 32'd63);
        cyc(0, 0, 0, 0, 1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            cyc(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 255)),
                bit'($urandom_range(0, 1)), bit'($urandom_range(0, 15) == 0),
                bit'($urandom_range(0, 2) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_acc_stage.md
MAC_ACC_STAGE -- requirements
Module: mac_acc_stage

Interface
REQ-001 SHALL have parameter TAPS, default 9: number of products per accumulation window (3x3 kernel).
REQ-002 SHALL have parameter ACC_W, default 13: signed accumulator and result width.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-005 SHALL have port product, input, 8: unsigned product from the upstream 4x4 multiplier.
REQ-006 SHALL have port sub, input, 1: 1 means subtract product (negative kernel weight), 0 means add.
REQ-007 SHALL have port in_valid, input, 1: product/sub valid this cycle.
REQ-008 SHALL have port in_ready, output, 1: stage can accept a product this cycle.
REQ-009 SHALL have port clr, input, 1: synchronous abort of the current window.
REQ-010 SHALL have port result, output, ACC_W: completed window sum, two's complement.
REQ-011 SHALL have port out_valid, output, 1: result valid.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts result.

Function
REQ-013 SHALL implement two states, ACCUM and HOLD.
REQ-014 In ACCUM, in_ready SHALL be 1 unless clr is 1; in HOLD, in_ready SHALL be 0.
REQ-015 A product SHALL be accepted when in_valid and in_ready are both 1 at a rising edge.
REQ-016 On acceptance, acc SHALL become acc + product (sub=0) or acc - product (sub=1), with product zero-extended to ACC_W, and tap counter SHALL increment.
REQ-017 Accepting the product with tap counter = TAPS-1 SHALL load result with the final sum, clear acc and counter, and enter HOLD with out_valid=1 on the next cycle (latency 1 cycle after last tap).
REQ-018 In HOLD, result and out_valid SHALL remain stable until out_valid and out_ready are both 1, then return to ACCUM with out_valid=0 next cycle.
REQ-019 out_ready while out_valid=0 SHALL have no effect.
REQ-020 in_valid=0 cycles in ACCUM SHALL leave acc and counter unchanged (gaps allowed).
REQ-021 clr=1 in ACCUM SHALL zero acc and counter; a coincident in_valid product SHALL be dropped (in_ready=0 that cycle).
REQ-022 clr=1 in HOLD SHALL be ignored; the pending result is still delivered.
REQ-023 Accumulation SHALL be modular in ACC_W bits, with no saturation; with defaults the range is -2295..+2295 and overflow cannot occur.

Reset
REQ-024 While rst=1, state SHALL be ACCUM, and acc, counter, result and out_valid SHALL be 0; in_ready SHALL be 1 after rst deasserts.
REQ-025 Reset mid-window or in HOLD SHALL discard all partial and pending data with no output pulse.

Configuration
REQ-026 With macro MAC_ACC_ABS_EN defined, result SHALL be loaded with the absolute value of the final sum (edge magnitude); without it, result SHALL be the signed sum.
REQ-027 MAC_ACC_ABS_EN SHALL affect only the value loaded into result, with no change to timing or handshakes.

Verification
REQ-028 Nine products of 225 with sub=0, back-to-back, and out_ready=1 -> out_valid=1 for one cycle, one cycle after the 9th acceptance, with result=2025.
REQ-029 Sobel-like sequence {10 add, 20 add, 10 add, 10 sub, 20 sub, 10 sub, 0, 0, 0} -> result=0; the sequence {0,...,10 sub,20 sub,30 sub} -> result=-60 without the macro, 60 with MAC_ACC_ABS_EN.
REQ-030 Window complete with out_ready=0 for 5 cycles -> result held, out_valid=1 and in_ready=0 throughout; in_valid products are not accepted; handshake occurs on the 6th cycle.
REQ-031 Four products accepted, then clr asserted together with in_valid -> that product is dropped; the next nine products of 1 give result=9.
REQ-032 rst asserted after 5 taps, then released, followed by nine products of 2 -> result=18; no output appears during or right after reset.
REQ-033 in_valid toggling every other cycle over nine products of 7 -> result=63; out_valid appears one cycle after the 9th acceptance.
